// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC sample scheduler.
package adc_sched_pkg;

    // Scheduler FSM encoding (2 bits)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    localparam int ADC_W           = 8;
    localparam int RF_AW           = 5;
    localparam int RF_DW           = 32;
    localparam int DEFAULT_ADC_REG = 1;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: one-cycle tick every SAMPLE_DIV cycles while run=1.
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 500
) (
    input  logic clock,
    input  logic ctrl_reset_n,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: held at zero outside run so each run period starts fresh
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign tick = run && (cnt_q == LAST);

    // Divider counter register
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Samples the ADC bus, averages 2**AVG_LOG2 samples and shares the regfile
// write port with the CPU writeback path (CPU always wins).
module adc_sample_scheduler
    import adc_sched_pkg::*;
#(
    parameter int SAMPLE_DIV = 500,
    parameter int AVG_LOG2   = 2,
    parameter int ADC_REG    = DEFAULT_ADC_REG
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic [ADC_W-1:0] JA,
    input  logic             enable,
    input  logic             overrun_clr,
    input  logic             cpu_we,
    input  logic [RF_AW-1:0] cpu_waddr,
    input  logic [RF_DW-1:0] cpu_wdata,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [RF_DW-1:0] rf_wdata,
    output logic             sample_valid,
    output logic             overrun
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);

    sched_state_e     state_q, state_d;
    logic [ADC_W-1:0] ja_meta_q, ja_s_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic [ADC_W-1:0] result_q, result_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;

    logic             tick;
    logic             active;
    logic             new_result;
    logic             adc_write;
    logic [ACC_W-1:0] sum;

    sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .run          (state_q == ST_RUN),
        .tick         (tick)
    );

    // Samples only count while running and not being stopped this cycle,
    // so a result can never appear on the cycle the FSM leaves RUN.
    assign active    = (state_q == ST_RUN) && enable;
    assign sum       = acc_q + ACC_W'(ja_s_q);
    assign adc_write = pending_q && !cpu_we;

    // Accumulator, sample count and result capture
    always_comb begin
        acc_d      = acc_q;
        scnt_d     = scnt_q;
        result_d   = result_q;
        new_result = 1'b0;
        if (!active) begin
            acc_d  = '0;
            scnt_d = '0;
        end else if (tick) begin
            if (scnt_q == LAST_SAMPLE) begin
                new_result = 1'b1;
                result_d   = ADC_W'(sum >> AVG_LOG2);
                acc_d      = '0;
                scnt_d     = '0;
            end else begin
                acc_d  = sum;
                scnt_d = scnt_q + CNT_W'(1);
            end
        end
    end

    // Pending flag and sticky overrun; a write in the same cycle as a new
    // result consumes the old one, so that case is not an overrun.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (new_result) begin
            pending_d = 1'b1;
        end else if (adc_write) begin
            pending_d = 1'b0;
        end
        if (new_result && pending_q && !adc_write) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = pending_q ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (!pending_q || adc_write) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Write-port arbiter: CPU passes straight through, ADC fills idle cycles
    always_comb begin
        rf_we        = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        sample_valid = 1'b0;
        if (cpu_we) begin
            rf_we    = 1'b1;
            rf_waddr = cpu_waddr;
            rf_wdata = cpu_wdata;
        end else if (pending_q) begin
            rf_we        = 1'b1;
            rf_waddr     = RF_AW'(ADC_REG);
            rf_wdata     = {{(RF_DW-ADC_W){1'b0}}, result_q};
            sample_valid = 1'b1;
        end
    end

    assign overrun = overrun_q;

    // State registers, including the two-flop ADC bus synchroniser
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q   <= ST_IDLE;
            ja_meta_q <= '0;
            ja_s_q    <= '0;
            acc_q     <= '0;
            scnt_q    <= '0;
            result_q  <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ja_meta_q <= JA;
            ja_s_q    <= ja_meta_q;
            acc_q     <= acc_d;
            scnt_q    <= scnt_d;
            result_q  <= result_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler (SAMPLE_DIV=4; AVG_LOG2=2 and 0).
module tb_adc_sample_scheduler;

    logic        clock;
    logic        ctrl_reset_n;
    logic [7:0]  JA;
    logic        enable, overrun_clr, cpu_we;
    logic [4:0]  cpu_waddr;
    logic [31:0] cpu_wdata;
    logic        rf_we, sample_valid, overrun;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [7:0]  b_ja;
    logic        b_enable;
    logic        b_rf_we, b_sample_valid, b_overrun;
    logic [4:0]  b_rf_waddr;
    logic [31:0] b_rf_wdata;
    logic        b_zero;
    logic [4:0]  b_zero_addr;
    logic [31:0] b_zero_data;

    int n_tests = 0;
    int n_fail  = 0;
    int writes_seen;

    adc_sample_scheduler #(.SAMPLE_DIV(4), .AVG_LOG2(2), .ADC_REG(1)) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .JA           (JA),
        .enable       (enable),
        .overrun_clr  (overrun_clr),
        .cpu_we       (cpu_we),
        .cpu_waddr    (cpu_waddr),
        .cpu_wdata    (cpu_wdata),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .sample_valid (sample_valid),
        .overrun      (overrun)
    );

    adc_sample_scheduler #(.SAMPLE_DIV(4), .AVG_LOG2(0), .ADC_REG(1)) dut_noavg (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .JA           (b_ja),
        .enable       (b_enable),
        .overrun_clr  (b_zero),
        .cpu_we       (b_zero),
        .cpu_waddr    (b_zero_addr),
        .cpu_wdata    (b_zero_data),
        .rf_we        (b_rf_we),
        .rf_waddr     (b_rf_waddr),
        .rf_wdata     (b_rf_wdata),
        .sample_valid (b_sample_valid),
        .overrun      (b_overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic show(input string what);
        $display("[TB] t=%0t %s we=%0b addr=%0d data=%h sv=%0b ovr=%0b",
                 $time, what, rf_we, rf_waddr, rf_wdata, sample_valid, overrun);
    endtask

    initial begin
        ctrl_reset_n = 1'b0;
        JA = 8'h00; enable = 1'b0; overrun_clr = 1'b0;
        cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
        b_ja = 8'hFF; b_enable = 1'b0;
        b_zero = 1'b0; b_zero_addr = '0; b_zero_data = '0;

        // Reset state
        #3;
        show("reset");
        chk("rst_we",   {31'b0, rf_we}, 32'd0);
        chk("rst_addr", {27'b0, rf_waddr}, 32'd0);
        chk("rst_data", rf_wdata, 32'd0);
        chk("rst_sv",   {31'b0, sample_valid}, 32'd0);
        chk("rst_ovr",  {31'b0, overrun}, 32'd0);
        #9 ctrl_reset_n = 1'b1;

        // Average of 10,20,30,41 -> 0x28
        step(1);
        enable = 1'b1; JA = 8'h10;
        step(4); chk("avg_early_we", {31'b0, rf_we}, 32'd0);
        step(1); JA = 8'h20;
        step(4); JA = 8'h30;
        step(4); JA = 8'h41;
        step(3); chk("avg_pre_we", {31'b0, rf_we}, 32'd0);
        step(1); show("avg write");
        chk("avg_we",   {31'b0, rf_we}, 32'd1);
        chk("avg_addr", {27'b0, rf_waddr}, 32'd1);
        chk("avg_data", rf_wdata, 32'h28);
        chk("avg_sv",   {31'b0, sample_valid}, 32'd1);
        step(1);
        chk("avg_post_we", {31'b0, rf_we}, 32'd0);
        chk("avg_post_sv", {31'b0, sample_valid}, 32'd0);

        // CPU holds the port for 3 cycles while a result (0x41) is pending
        step(14);
        cpu_we = 1'b1; cpu_waddr = 5'd5; cpu_wdata = 32'hDEADBEEF;
        step(1); show("cpu write");
        chk("cpu_we",   {31'b0, rf_we}, 32'd1);
        chk("cpu_addr", {27'b0, rf_waddr}, 32'd5);
        chk("cpu_data", rf_wdata, 32'hDEADBEEF);
        chk("cpu_sv",   {31'b0, sample_valid}, 32'd0);
        step(2);
        chk("cpu_hold_data", rf_wdata, 32'hDEADBEEF);
        cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
        #1; show("deferred adc");
        chk("defer_addr", {27'b0, rf_waddr}, 32'd1);
        chk("defer_data", rf_wdata, 32'h41);
        chk("defer_sv",   {31'b0, sample_valid}, 32'd1);
        step(1);
        chk("defer_post_we", {31'b0, rf_we}, 32'd0);
        JA = 8'h80;

        // Overrun: results 0x70 then 0x80 while CPU is busy
        step(12);
        cpu_we = 1'b1; cpu_waddr = 5'd7; cpu_wdata = 32'h1234;
        step(16);
        chk("ovr_before", {31'b0, overrun}, 32'd0);
        chk("ovr_cpu_addr", {27'b0, rf_waddr}, 32'd7);
        step(1); show("overrun");
        chk("ovr_set", {31'b0, overrun}, 32'd1);
        cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0; overrun_clr = 1'b1;
        #1;
        chk("ovr_newer_data", rf_wdata, 32'h80);
        chk("ovr_newer_addr", {27'b0, rf_waddr}, 32'd1);
        step(1); overrun_clr = 1'b0;
        chk("ovr_cleared", {31'b0, overrun}, 32'd0);
        chk("ovr_single_write", {31'b0, rf_we}, 32'd0);

        // Drain: enable drops with a result pending and a partial average
        step(14);
        cpu_we = 1'b1; cpu_waddr = 5'd3; cpu_wdata = 32'h55;
        step(1); JA = 8'hF0;
        chk("drain_cpu_addr", {27'b0, rf_waddr}, 32'd3);
        step(9); enable = 1'b0;
        step(1);
        step(1); cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
        #1; show("drain write");
        chk("drain_data", rf_wdata, 32'h80);
        chk("drain_sv",   {31'b0, sample_valid}, 32'd1);
        step(1);
        chk("drain_post_we", {31'b0, rf_we}, 32'd0);
        writes_seen = 0;
        for (int i = 0; i < 24; i++) begin
            step(1);
            if (rf_we !== 1'b0 || sample_valid !== 1'b0) writes_seen++;
        end
        chk("drain_no_partial", writes_seen, 0);

        // Reset mid-RUN with a pending result
        JA = 8'h22; enable = 1'b1;
        cpu_we = 1'b1; cpu_waddr = 5'd9; cpu_wdata = 32'hAAAA;
        step(17);
        chk("mid_cpu_addr", {27'b0, rf_waddr}, 32'd9);
        cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
        ctrl_reset_n = 1'b0;
        #1; show("mid reset");
        chk("mid_rst_we",   {31'b0, rf_we}, 32'd0);
        chk("mid_rst_data", rf_wdata, 32'd0);
        chk("mid_rst_sv",   {31'b0, sample_valid}, 32'd0);
        #2 ctrl_reset_n = 1'b1;
        writes_seen = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (rf_we !== 1'b0) writes_seen++;
        end
        chk("mid_no_stale", writes_seen, 0);
        step(1); show("post reset write");
        chk("mid_new_we",   {31'b0, rf_we}, 32'd1);
        chk("mid_new_data", rf_wdata, 32'h22);
        enable = 1'b0;

        // No averaging: write every 4 cycles with data 0xFF
        b_enable = 1'b1;
        step(5);
        $display("[TB] t=%0t noavg we=%0b data=%h sv=%0b", $time, b_rf_we, b_rf_wdata, b_sample_valid);
        chk("noavg_we1",   {31'b0, b_rf_we}, 32'd1);
        chk("noavg_data1", b_rf_wdata, 32'hFF);
        chk("noavg_sv1",   {31'b0, b_sample_valid}, 32'd1);
        step(1); chk("noavg_gap1", {31'b0, b_rf_we}, 32'd0);
        step(2); chk("noavg_gap3", {31'b0, b_rf_we}, 32'd0);
        step(1);
        $display("[TB] t=%0t noavg we=%0b data=%h sv=%0b", $time, b_rf_we, b_rf_wdata, b_sample_valid);
        chk("noavg_we2", {31'b0, b_rf_we}, 32'd1);
        step(4);
        chk("noavg_we3",   {31'b0, b_rf_we}, 32'd1);
        chk("noavg_data3", b_rf_wdata, 32'hFF);
        chk("noavg_ovr",   {31'b0, b_overrun}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
